reg_wb_queue: RTL and testbench

- Write-side companion of the 15-entry register file: buffers register writebacks from two pipeline sources, the ALU result and the load data return.
- Drains the buffer as at most one regfile write per cycle on we3/wa3/wd3.
- Publishes a per-register pending mask so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/reg_wb_queue.sv | 181 ++++++++++++++++++
 tb/tb_reg_wb_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: write-side companion of the 15-entry register file.
// It buffers writebacks from two pipeline sources (load return and ALU),
// drains at most one regfile write per cycle on we3/wa3/wd3, and publishes
// a per-register pending mask so decode can stall on RAW hazards.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   alu_valid/alu_rd/alu_data  ALU writeback request
//   mem_valid/mem_rd/mem_data  load-return writeback request
//   in_ready                   both sources may enqueue this cycle
//   we3/wa3/wd3                registered regfile write port
//   pending[14:0]              register r has a queued or in-flight write
//   empty                      queue and output stage both idle
//   err[1:0]                   sticky: [0] overflow drop, [1] r15 write dropped
//   fa1/fa2 -> fhit1/fdata1, fhit2/fdata2   forwarding lookups
//
// Optional feature: define REG_WB_QUEUE_FWD_EN to build the forwarding
// lookup. Without it fhit*/fdata* are tied to zero.

module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [3:0]    alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    input  logic [3:0]    mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          in_ready,
    output logic          we3,
    output logic [3:0]    wa3,
    output logic [DW-1:0] wd3,
    output logic [14:0]   pending,
    output logic          empty,
    output logic [1:0]    err,
    input  logic [3:0]    fa1,
    input  logic [3:0]    fa2,
    output logic          fhit1,
    output logic          fhit2,
    output logic [DW-1:0] fdata1,
    output logic [DW-1:0] fdata2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

    logic [3:0]    rd_q_r   [DEPTH];
    logic [DW-1:0] data_q_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          we3_r;
    logic [3:0]    wa3_r;
    logic [DW-1:0] wd3_r;
    logic [1:0]    err_r;

    logic          in_ready_s;
    logic          mem_enq_s;
    logic          alu_enq_s;
    logic          deq_s;
    logic [1:0]    enq_n_s;
    logic [AW-1:0] alu_slot_s;
    logic [DEPTH-1:0] valid_s;
    logic [14:0]   pending_s;

    // Enqueue/dequeue decisions; in_ready needs two free slots so both sources can always land.
    always_comb begin
        in_ready_s = (count_r <= DEPTH_M2);
        mem_enq_s  = mem_valid && in_ready_s && (mem_rd != 4'd15);
        alu_enq_s  = alu_valid && in_ready_s && (alu_rd != 4'd15);
        deq_s      = (count_r != {CW{1'b0}});
        enq_n_s    = {1'b0, mem_enq_s} + {1'b0, alu_enq_s};
        // mem is the older instruction, so it takes the tail slot first
        alu_slot_s = mem_enq_s ? (tail_r + AW'(1'b1)) : tail_r;
    end

    // Per-slot occupancy: slot i is live when its distance from head is below count.
    always_comb begin
        valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i] = ({1'b0, AW'(AW'(i) - head_r)} < count_r);
        end
    end

    // Pending mask: any live queue entry or the output stage targeting register r.
    always_comb begin
        pending_s = 15'd0;
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                pending_s[r] = pending_s[r] | (valid_s[i] && (rd_q_r[i] == 4'(r)));
            end
            pending_s[r] = pending_s[r] | (we3_r && (wa3_r == 4'(r)));
        end
    end

    // Queue storage, pointers, output stage and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q_r[i]   <= 4'd0;
                data_q_r[i] <= {DW{1'b0}};
            end
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            we3_r   <= 1'b0;
            wa3_r   <= 4'd0;
            wd3_r   <= {DW{1'b0}};
            err_r   <= 2'b00;
        end else begin
            if (mem_enq_s) begin
                rd_q_r[tail_r]   <= mem_rd;
                data_q_r[tail_r] <= mem_data;
            end
            if (alu_enq_s) begin
                rd_q_r[alu_slot_s]   <= alu_rd;
                data_q_r[alu_slot_s] <= alu_data;
            end
            if (deq_s) begin
                we3_r  <= 1'b1;
                wa3_r  <= rd_q_r[head_r];
                wd3_r  <= data_q_r[head_r];
                head_r <= head_r + AW'(1'b1);
            end else begin
                we3_r  <= 1'b0;
            end
            tail_r  <= tail_r + AW'(enq_n_s);
            count_r <= count_r + CW'(enq_n_s) - CW'(deq_s);
            err_r[0] <= err_r[0]
                      | (mem_valid && (mem_rd != 4'd15) && !in_ready_s)
                      | (alu_valid && (alu_rd != 4'd15) && !in_ready_s);
            err_r[1] <= err_r[1]
                      | (mem_valid && (mem_rd == 4'd15))
                      | (alu_valid && (alu_rd == 4'd15));
        end
    end

`ifdef REG_WB_QUEUE_FWD_EN
    // Forwarding lookup: walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fhit1  = we3_r && (wa3_r == fa1) && (fa1 != 4'd15);
        fdata1 = fhit1 ? wd3_r : {DW{1'b0}};
        fhit2  = we3_r && (wa3_r == fa2) && (fa2 != 4'd15);
        fdata2 = fhit2 ? wd3_r : {DW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_s[head_r + AW'(k)] && (rd_q_r[head_r + AW'(k)] == fa1) && (fa1 != 4'd15)) begin
                fhit1  = 1'b1;
                fdata1 = data_q_r[head_r + AW'(k)];
            end else begin
                fdata1 = fdata1;
            end
            if (valid_s[head_r + AW'(k)] && (rd_q_r[head_r + AW'(k)] == fa2) && (fa2 != 4'd15)) begin
                fhit2  = 1'b1;
                fdata2 = data_q_r[head_r + AW'(k)];
            end else begin
                fdata2 = fdata2;
            end
        end
    end
`else
    logic fwd_unused_s;
    assign fwd_unused_s = ^{fa1, fa2};
    assign fhit1  = 1'b0;
    assign fhit2  = 1'b0;
    assign fdata1 = {DW{1'b0}};
    assign fdata2 = {DW{1'b0}};
`endif

    assign in_ready = in_ready_s;
    assign we3      = we3_r;
    assign wa3      = wa3_r;
    assign wd3      = wd3_r;
    assign pending  = pending_s;
    assign empty    = (count_r == {CW{1'b0}}) && !we3_r;
    assign err      = err_r;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed steps followed by a random
// phase, all compared against a queue-based reference model.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0;
    logic [3:0]    alu_rd = 4'd0;
    logic [DW-1:0] alu_data = 32'd0;
    logic          mem_valid = 1'b0;
    logic [3:0]    mem_rd = 4'd0;
    logic [DW-1:0] mem_data = 32'd0;
    logic          in_ready;
    logic          we3;
    logic [3:0]    wa3;
    logic [DW-1:0] wd3;
    logic [14:0]   pending;
    logic          empty;
    logic [1:0]    err;
    logic [3:0]    fa1 = 4'd0;
    logic [3:0]    fa2 = 4'd0;
    logic          fhit1, fhit2;
    logic [DW-1:0] fdata1, fdata2;

    reg_wb_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .in_ready(in_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
        .pending(pending), .empty(empty), .err(err),
        .fa1(fa1), .fa2(fa2), .fhit1(fhit1), .fhit2(fhit2),
        .fdata1(fdata1), .fdata2(fdata2)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] rd; logic [31:0] data; } ent_t;

    // reference model state
    ent_t        q[$];
    bit          m_we = 1'b0;
    logic [3:0]  m_wa = 4'd0;
    logic [31:0] m_wd = 32'd0;
    logic [1:0]  m_err = 2'b00;

    int test_cnt = 0;
    int fail_cnt = 0;
    int wr_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one source request as seen by the model at a clock edge
    task automatic model_src(input bit v, input logic [3:0] rd, input logic [31:0] d, input bit rdy);
        if (v) begin
            if (rd == 4'd15) m_err[1] = 1'b1;
            else if (!rdy) m_err[0] = 1'b1;
            else q.push_back('{rd: rd, data: d});
        end
    endtask

    task automatic model_edge(input bit av, input logic [3:0] ard, input logic [31:0] ad,
                              input bit mv, input logic [3:0] mrd, input logic [31:0] md);
        bit rdy;
        ent_t e;
        rdy = (DEPTH - q.size()) >= 2;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_we = 1'b1; m_wa = e.rd; m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
        model_src(mv, mrd, md, rdy);   // older instruction first
        model_src(av, ard, ad, rdy);
    endtask

    task automatic fwd_exp(input logic [3:0] fa, output bit hit, output logic [31:0] d);
        hit = 1'b0; d = 32'd0;
`ifdef REG_WB_QUEUE_FWD_EN
        if (fa != 4'd15) begin
            for (int i = q.size() - 1; i >= 0 && !hit; i--) begin
                if (q[i].rd == fa) begin hit = 1'b1; d = q[i].data; end
            end
            if (!hit && m_we && m_wa == fa) begin hit = 1'b1; d = m_wd; end
        end
`endif
    endtask

    task automatic check_all(input string ph);
        logic [14:0] p;
        bit h;
        logic [31:0] d;
        p = 15'd0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        if (m_we) p[m_wa] = 1'b1;
        if (we3) wr_cnt++;
        chk({ph, ".we3"}, 64'(we3), 64'(m_we));
        chk({ph, ".wa3"}, 64'(wa3), 64'(m_wa));
        chk({ph, ".wd3"}, 64'(wd3), 64'(m_wd));
        chk({ph, ".pending"}, 64'(pending), 64'(p));
        chk({ph, ".empty"}, 64'(empty), 64'(q.size() == 0 && !m_we));
        chk({ph, ".in_ready"}, 64'(in_ready), 64'((DEPTH - q.size()) >= 2));
        chk({ph, ".err"}, 64'(err), 64'(m_err));
        fwd_exp(fa1, h, d);
        chk({ph, ".fhit1"}, 64'(fhit1), 64'(h));
        chk({ph, ".fdata1"}, 64'(fdata1), 64'(d));
        fwd_exp(fa2, h, d);
        chk({ph, ".fhit2"}, 64'(fhit2), 64'(h));
        chk({ph, ".fdata2"}, 64'(fdata2), 64'(d));
    endtask

    task automatic step(input string ph, input bit av, input logic [3:0] ard, input logic [31:0] ad,
                        input bit mv, input logic [3:0] mrd, input logic [31:0] md);
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        @(posedge clk);
        model_edge(av, ard, ad, mv, mrd, md);
        #1;
        check_all(ph);
    endtask

    task automatic idle(input string ph);
        step(ph, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0; m_wa = 4'd0; m_wd = 32'd0; m_err = 2'b00;
    endtask

    initial begin
        // reset state (asserted from time 0)
        #1;
        chk("rst.we3", 64'(we3), 64'd0);
        chk("rst.wa3", 64'(wa3), 64'd0);
        chk("rst.wd3", 64'(wd3), 64'd0);
        chk("rst.pending", 64'(pending), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // single ALU write
        step("alu1", 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        chk("alu1.pend_c0", 64'(pending[3]), 64'd1);
        chk("alu1.we3_c0", 64'(we3), 64'd0);
        idle("alu1");
        chk("alu1.we3_c1", 64'(we3), 64'd1);
        chk("alu1.wd3_c1", 64'(wd3), 64'hDEADBEEF);
        chk("alu1.pend_c1", 64'(pending[3]), 64'd1);
        idle("alu1");
        chk("alu1.we3_c2", 64'(we3), 64'd0);
        chk("alu1.pend_c2", 64'(pending[3]), 64'd0);
        chk("alu1.empty_c2", 64'(empty), 64'd1);

        // dual source, same cycle, same register: mem is older
        step("dual", 1'b1, 4'd5, 32'h22, 1'b1, 4'd5, 32'h11);
        idle("dual");
        chk("dual.first", 64'(wd3), 64'h11);
        idle("dual");
        chk("dual.second", 64'(wd3), 64'h22);
        chk("dual.pend_hold", 64'(pending[5]), 64'd1);
        idle("dual");
        chk("dual.pend_clr", 64'(pending[5]), 64'd0);

        // write to r15 is dropped
        step("r15", 1'b1, 4'd15, 32'h55, 1'b0, 4'd0, 32'd0);
        chk("r15.err1", 64'(err[1]), 64'd1);
        chk("r15.pending", 64'(pending), 64'd0);
        idle("r15");
        chk("r15.no_we", 64'(we3), 64'd0);

        // fill and overflow
        wr_cnt = 0;
        step("ovf", 1'b1, 4'd2, 32'hA2, 1'b1, 4'd1, 32'hA1);
        step("ovf", 1'b1, 4'd4, 32'hA4, 1'b1, 4'd3, 32'hA3);
        chk("ovf.in_ready", 64'(in_ready), 64'd0);
        step("ovf", 1'b1, 4'd6, 32'hA6, 1'b0, 4'd0, 32'd0);
        chk("ovf.err0", 64'(err[0]), 64'd1);
        for (int i = 0; i < 5; i++) idle("ovf");
        chk("ovf.writes", 64'(wr_cnt), 64'd4);

        // forwarding: youngest r7 value wins; r15 never hits
        fa1 = 4'd7; fa2 = 4'd15;
        step("fwd", 1'b1, 4'd7, 32'h2, 1'b1, 4'd7, 32'h1);
`ifdef REG_WB_QUEUE_FWD_EN
        chk("fwd.hit", 64'(fhit1), 64'd1);
        chk("fwd.data", 64'(fdata1), 64'h2);
`endif
        for (int i = 0; i < 3; i++) idle("fwd");
        chk("fwd.miss", 64'(fhit1), 64'd0);

        // reset mid-drain with 3 entries queued
        step("rstm", 1'b1, 4'd2, 32'hB2, 1'b1, 4'd1, 32'hB1);
        step("rstm", 1'b1, 4'd4, 32'hB4, 1'b1, 4'd3, 32'hB3);
        idle("rstm");
        @(negedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rstm.we3", 64'(we3), 64'd0);
        chk("rstm.pending", 64'(pending), 64'd0);
        chk("rstm.empty", 64'(empty), 64'd1);
        check_all("rstm");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) idle("rstm");
        chk("rstm.no_writes", 64'(wr_cnt), 64'd0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit av, mv;
            logic [3:0] ard, mrd;
            av  = ($urandom_range(0, 99) < 60);
            mv  = ($urandom_range(0, 99) < 45);
            ard = ($urandom_range(0, 24) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            mrd = ($urandom_range(0, 24) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            fa1 = 4'($urandom_range(0, 15));
            fa2 = 4'($urandom_range(0, 15));
            step("rnd", av, ard, $urandom, mv, mrd, $urandom);
        end
        for (int i = 0; i < 6; i++) idle("tail");
        chk("tail.empty", 64'(empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
